fsm_ctrl_flow: RTL and testbench
================================

# fsm_ctrl_flow

Parametrised control-flow FSM for the Control Unit, successor to the basic branch/jump FSM. It sequences JAL, JALR and all six B-type branches through the DataFlow. Over the basic FSM it adds:
- synchronous reset and a `done` handshake;
- x0-write suppression;
- illegal-funct3 detection;
- instruction-address-misaligned trap detection for a configurable IALIGN.

It sits beside the other FSMs under the op decoder and drives the same DataFlow load/select lines.

## Interface
- XLEN, 64, datapath width; width of `target`.
- IALIGN, 32, instruction alignment in bits; legal values 32 or 16.
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  leave IDLE; sampled only in IDLE.
- ins  in  32  current instruction (funct3 = ins[14:12], rd = ins[11:7]).
- code  in  32  op decoder one-hot; code[24]=1 branch, code[25]=1 JAL, else JALR.
- eq, ls, lu  in  1 each  ALU compare flags (equal, signed less, unsigned less).
- target  in  XLEN  candidate next PC from ALU output register (JAL/JALR) or branch adder; valid in CHECK.
- func3  out  3  ALU function, constant 3'b000.
- sel_rd  out  2  rd source select, constant 2'b11 (PC+4).
- load_rs1, load_rs2, load_alu, load_pc_alu, load_pc, load_regfile  out  1 each  register enables.
- sub_sra, sel_alu_a, sel_alu_b, sel_pc_alu, sel_pc_next  out  1 each  ALU/PC selects.
- done  out  1  one-cycle pulse: instruction retired or trapped; FSM is back in IDLE next cycle.
- trap_misaligned  out  1  one-cycle pulse in TRAP for a misaligned target.
- trap_illegal  out  1  one-cycle pulse in TRAP for reserved branch funct3 (010, 011).

## Operation
- States, 3-bit encoding:
  - IDLE 000, DECODE 001, EXEC_J 010, EXEC_B 011, CHECK 100, WB_J 110, WB_B 111, TRAP 101.
- Transitions:
  - IDLE→DECODE when start, else stay.
  - DECODE→EXEC_B if code[24], else EXEC_J. Exception: branch with funct3 ∈ {010, 011} goes DECODE→TRAP (illegal).
  - EXEC_J, EXEC_B→CHECK.
  - CHECK→TRAP if `taken` and misaligned; else WB_J for jumps, WB_B for branches.
  - WB_J, WB_B, TRAP→IDLE.
- Internal `taken` register:
  - Set to 1 on entering EXEC_J.
  - On entering CHECK from EXEC_B, captures branch_cond(funct3, eq, ls, lu): 000 eq, 001 ~eq, 100 ls, 101 ~ls, 110 lu, 111 ~lu.
- Misaligned rule:
  - IALIGN=32: target[1] | (target[0] & ~JALR).
  - IALIGN=16: target[0] & ~JALR.
  - JALR bit 0 is always ignored (ISA clears it).
  - Not-taken branches never trap.
- Per-state outputs (all others 0):
  - DECODE: load_rs1, load_rs2.
  - EXEC_J: sel_alu_a = ~code[25] (PC for JAL, rs1 for JALR), sel_alu_b, load_alu, load_pc_alu.
  - EXEC_B: sub_sra.
  - CHECK: none.
  - WB_J: load_pc, sel_pc_next, load_regfile = (rd != 0), done.
  - WB_B: load_pc, sel_pc_alu = taken, done.
  - TRAP: done, plus trap_misaligned or trap_illegal.
- TRAP writes neither PC nor regfile.

## Timing
- All outputs are registered and computed from `next`, so they are asserted during the cycle the FSM occupies the named state.
- Reset:
  - rst high at an edge forces state=IDLE, taken=0 and every registered output to 0 on that edge, from any state.
  - func3 and sel_rd remain constant.
- Latency from start high in IDLE (cycle 0):
  - DECODE in cycle 1, EXEC in 2, CHECK in 3.
  - WB or TRAP in 4 with done; IDLE in 5.
  - Illegal branch: TRAP in cycle 2.
- start while not IDLE is ignored. start held high continuously re-enters DECODE the cycle after IDLE.
- Flags are sampled only at the EXEC_B→CHECK edge. target is sampled only in CHECK.

## Structure
- Package `ctrl_flow_pkg`: state localparams, CODE_BRANCH=24, CODE_JAL=25, branch funct3 constants (BEQ…BGEU), misaligned helper function parametrised on IALIGN.
- Sub-module `branch_cond`, combinational: funct3 + eq/ls/lu → taken, illegal. It is reused by later pipelined control.

## Test plan
- JAL, rd=5, target=0x1000, IALIGN=32 → cycle 4: load_pc=1, sel_pc_next=1, load_regfile=1, done=1; cycle 5 all 0.
- JALR, rd=0, target=0x1001 → no trap (bit 0 ignored); WB_J with load_regfile=0, load_pc=1.
- BLT funct3=100 with ls=1 → WB_B sel_pc_alu=1. Same instruction with ls=0 and target=0x1002 → sel_pc_alu=0, no trap.
- BEQ, eq=1, target=0x1002: IALIGN=32 → TRAP, trap_misaligned=1, load_pc=0. IALIGN=16 → WB_B, sel_pc_alu=1.
- Branch funct3=010 → TRAP in cycle 2 with trap_illegal=1, done=1.
- rst asserted in EXEC_J → next edge state IDLE with all outputs 0. start pulsed during WB_B → ignored, IDLE follows.

Source files
------------

// File: rtl/fsm_ctrl_flow_pkg.sv
// Shared definitions for the control-flow FSM: state encoding, op-decoder
// bit positions, branch funct3 codes and the target alignment rule.
package ctrl_flow_pkg;

  // Fixed 3-bit encoding; TRAP and the WB states share the top bit with CHECK
  // so that every post-EXEC state has state[2] set.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_DECODE = 3'b001,
    ST_EXEC_J = 3'b010,
    ST_EXEC_B = 3'b011,
    ST_CHECK  = 3'b100,
    ST_TRAP   = 3'b101,
    ST_WB_J   = 3'b110,
    ST_WB_B   = 3'b111
  } state_t;

  // Bit positions in the op decoder one-hot code.
  localparam int CODE_BRANCH = 24;
  localparam int CODE_JAL    = 25;

  // B-type funct3 values; 010 and 011 are reserved.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Target misalignment for the given instruction alignment (32 or 16 bits).
  // JALR clears bit 0 of its target, so that bit never counts for JALR.
  function automatic logic is_misaligned(input int ialign,
                                         input logic [1:0] tgt_lo,
                                         input logic is_jalr);
    logic bit0_bad;
    bit0_bad = tgt_lo[0] & ~is_jalr;
    if (ialign == 16) return bit0_bad;
    return tgt_lo[1] | bit0_bad;
  endfunction

endpackage

// File: rtl/fsm_ctrl_flow_branch_cond.sv
// Combinational branch condition: maps funct3 and the ALU compare flags to
// a taken decision, and flags the reserved funct3 codes as illegal.
module branch_cond
  import ctrl_flow_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       eq,
  input  logic       ls,
  input  logic       lu,
  output logic       taken,
  output logic       illegal
);

  // Decode funct3 into the branch outcome.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned, which would infer a latch.
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = ~eq;
      F3_BLT:  taken = ls;
      F3_BGE:  taken = ~ls;
      F3_BLTU: taken = lu;
      F3_BGEU: taken = ~lu;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fsm_ctrl_flow.sv
// Control-flow FSM: sequences JAL, JALR and B-type branches through the
// DataFlow, with done handshake, x0-write suppression, illegal-funct3 and
// misaligned-target traps. Outputs are registered from the next state so
// they are valid for the whole cycle the FSM spends in the named state.
module fsm_ctrl_flow
  import ctrl_flow_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int IALIGN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [31:0]     ins,
  input  logic [31:0]     code,
  input  logic            eq,
  input  logic            ls,
  input  logic            lu,
  input  logic [XLEN-1:0] target,
  output logic [2:0]      func3,
  output logic [1:0]      sel_rd,
  output logic            load_rs1,
  output logic            load_rs2,
  output logic            load_alu,
  output logic            load_pc_alu,
  output logic            load_pc,
  output logic            load_regfile,
  output logic            sub_sra,
  output logic            sel_alu_a,
  output logic            sel_alu_b,
  output logic            sel_pc_alu,
  output logic            sel_pc_next,
  output logic            done,
  output logic            trap_misaligned,
  output logic            trap_illegal
);

  state_t     state;
  state_t     state_next;
  logic       taken_q;
  logic       cond_taken;
  logic       cond_illegal;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       is_branch;
  logic       is_jalr;
  logic       misaligned;
  logic       unused_bits;

  assign funct3    = ins[14:12];
  assign rd        = ins[11:7];
  assign is_branch = code[CODE_BRANCH];
  assign is_jalr   = ~code[CODE_BRANCH] & ~code[CODE_JAL];
  assign misaligned = is_misaligned(IALIGN, target[1:0], is_jalr);

  // The ALU always adds and rd always takes PC+4 for these instructions.
  assign func3  = 3'b000;
  assign sel_rd = 2'b11;

  // Only funct3, rd, two code bits and the low target bits matter here.
  assign unused_bits = ^{ins[31:15], ins[6:0], code[31:26], code[23:0],
                         target[XLEN-1:2]};

  branch_cond u_branch_cond (
    .funct3  (funct3),
    .eq      (eq),
    .ls      (ls),
    .lu      (lu),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  // Next-state selection.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_DECODE;
      ST_DECODE: begin
        if (is_branch) state_next = cond_illegal ? ST_TRAP : ST_EXEC_B;
        else           state_next = ST_EXEC_J;
      end
      ST_EXEC_J,
      ST_EXEC_B: state_next = ST_CHECK;
      ST_CHECK: begin
        if (taken_q && misaligned) state_next = ST_TRAP;
        else if (is_branch)        state_next = ST_WB_B;
        else                       state_next = ST_WB_J;
      end
      default:   state_next = ST_IDLE;  // WB_J, WB_B, TRAP
    endcase
  end

  // State, taken flag and registered outputs; reset is synchronous.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples values from
    // before this edge, independent of statement order.
    if (rst) begin
      state           <= ST_IDLE;
      taken_q         <= 1'b0;
      load_rs1        <= 1'b0;
      load_rs2        <= 1'b0;
      load_alu        <= 1'b0;
      load_pc_alu     <= 1'b0;
      load_pc         <= 1'b0;
      load_regfile    <= 1'b0;
      sub_sra         <= 1'b0;
      sel_alu_a       <= 1'b0;
      sel_alu_b       <= 1'b0;
      sel_pc_alu      <= 1'b0;
      sel_pc_next     <= 1'b0;
      done            <= 1'b0;
      trap_misaligned <= 1'b0;
      trap_illegal    <= 1'b0;
    end else begin
      state <= state_next;

      // Jumps are always taken; branches latch their condition on the way
      // from EXEC_B into CHECK, the only edge where the flags are valid.
      if (state_next == ST_EXEC_J)  taken_q <= 1'b1;
      else if (state == ST_EXEC_B)  taken_q <= cond_taken;

      load_rs1        <= (state_next == ST_DECODE);
      load_rs2        <= (state_next == ST_DECODE);
      sel_alu_a       <= (state_next == ST_EXEC_J) & ~code[CODE_JAL];
      sel_alu_b       <= (state_next == ST_EXEC_J);
      load_alu        <= (state_next == ST_EXEC_J);
      load_pc_alu     <= (state_next == ST_EXEC_J);
      sub_sra         <= (state_next == ST_EXEC_B);
      load_pc         <= (state_next == ST_WB_J) | (state_next == ST_WB_B);
      sel_pc_next     <= (state_next == ST_WB_J);
      load_regfile    <= (state_next == ST_WB_J) && (rd != 5'd0);
      sel_pc_alu      <= (state_next == ST_WB_B) & taken_q;
      done            <= (state_next == ST_WB_J) | (state_next == ST_WB_B) |
                         (state_next == ST_TRAP);
      trap_misaligned <= (state_next == ST_TRAP) && (state == ST_CHECK);
      trap_illegal    <= (state_next == ST_TRAP) && (state == ST_DECODE);
    end
  end

endmodule

// File: tb/tb_fsm_ctrl_flow.sv
// Self-checking bench for fsm_ctrl_flow: two instances (IALIGN 32 and 16)
// share stimulus; a per-instruction behavioural model yields the expected
// output vector for each cycle, compared on every falling edge.
`timescale 1ns/1ps
module tb_fsm_ctrl_flow;

  typedef struct packed {
    logic load_rs1, load_rs2, load_alu, load_pc_alu, load_pc, load_regfile;
    logic sub_sra, sel_alu_a, sel_alu_b, sel_pc_alu, sel_pc_next;
    logic done, trap_misaligned, trap_illegal;
  } out_t;

  localparam int KIND_BR   = 0;
  localparam int KIND_JAL  = 1;
  localparam int KIND_JALR = 2;

  logic        clk = 1'b0;
  logic        rst, start, eq, ls, lu;
  logic [31:0] ins, code;
  logic [63:0] target;

  logic [1:0] load_rs1, load_rs2, load_alu, load_pc_alu, load_pc, load_regfile;
  logic [1:0] sub_sra, sel_alu_a, sel_alu_b, sel_pc_alu, sel_pc_next;
  logic [1:0] done, trap_misaligned, trap_illegal;
  logic [2:0] func3_o [2];
  logic [1:0] sel_rd_o [2];
  out_t       obs [2];

  out_t exp_q [2][$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   checking_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fsm_ctrl_flow #(.XLEN(64), .IALIGN(g == 0 ? 32 : 16)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .ins             (ins),
      .code            (code),
      .eq              (eq),
      .ls              (ls),
      .lu              (lu),
      .target          (target),
      .func3           (func3_o[g]),
      .sel_rd          (sel_rd_o[g]),
      .load_rs1        (load_rs1[g]),
      .load_rs2        (load_rs2[g]),
      .load_alu        (load_alu[g]),
      .load_pc_alu     (load_pc_alu[g]),
      .load_pc         (load_pc[g]),
      .load_regfile    (load_regfile[g]),
      .sub_sra         (sub_sra[g]),
      .sel_alu_a       (sel_alu_a[g]),
      .sel_alu_b       (sel_alu_b[g]),
      .sel_pc_alu      (sel_pc_alu[g]),
      .sel_pc_next     (sel_pc_next[g]),
      .done            (done[g]),
      .trap_misaligned (trap_misaligned[g]),
      .trap_illegal    (trap_illegal[g])
    );
    assign obs[g] = {load_rs1[g], load_rs2[g], load_alu[g], load_pc_alu[g],
                     load_pc[g], load_regfile[g], sub_sra[g], sel_alu_a[g],
                     sel_alu_b[g], sel_pc_alu[g], sel_pc_next[g], done[g],
                     trap_misaligned[g], trap_illegal[g]};
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs of one instruction, cycle 1 (DECODE) onward.
  task automatic model(input int kind, input logic [2:0] f3, input logic [4:0] rd,
                       input logic eq_i, input logic ls_i, input logic lu_i,
                       input logic [63:0] tgt, input int ialign,
                       output int len, output out_t seq [4]);
    bit taken;
    bit mis;
    logic [63:0] eff;
    for (int i = 0; i < 4; i++) seq[i] = '0;
    seq[0].load_rs1 = 1'b1;
    seq[0].load_rs2 = 1'b1;
    if (kind == KIND_BR && (f3 == 3'd2 || f3 == 3'd3)) begin
      len = 2;
      seq[1].done = 1'b1;
      seq[1].trap_illegal = 1'b1;
      return;
    end
    len = 4;
    if (kind == KIND_BR) begin
      case (f3)
        3'd0:    taken = eq_i;
        3'd1:    taken = !eq_i;
        3'd4:    taken = ls_i;
        3'd5:    taken = !ls_i;
        3'd6:    taken = lu_i;
        default: taken = !lu_i;
      endcase
      seq[1].sub_sra = 1'b1;
    end else begin
      taken = 1'b1;
      seq[1].sel_alu_a   = (kind == KIND_JALR);
      seq[1].sel_alu_b   = 1'b1;
      seq[1].load_alu    = 1'b1;
      seq[1].load_pc_alu = 1'b1;
    end
    eff = (kind == KIND_JALR) ? (tgt & ~64'd1) : tgt;
    mis = taken && ((eff % 64'(ialign / 8)) != 64'd0);
    if (mis) begin
      seq[3].done = 1'b1;
      seq[3].trap_misaligned = 1'b1;
    end else if (kind == KIND_BR) begin
      seq[3].load_pc    = 1'b1;
      seq[3].sel_pc_alu = taken;
      seq[3].done       = 1'b1;
    end else begin
      seq[3].load_pc      = 1'b1;
      seq[3].sel_pc_next  = 1'b1;
      seq[3].load_regfile = (rd != 5'd0);
      seq[3].done         = 1'b1;
    end
  endtask

  // Compare both instances against the expected stream every cycle.
  always @(negedge clk) begin
    if (checking_en) begin
      for (int g = 0; g < 2; g++) begin
        out_t e;
        e = (exp_q[g].size() > 0) ? exp_q[g].pop_front() : out_t'(0);
        check($sformatf("outputs ialign%0d", (g == 0) ? 32 : 16),
              64'(obs[g]), 64'(e));
        check("func3 const", 64'(func3_o[g]), 64'(3'b000));
        check("sel_rd const", 64'(sel_rd_o[g]), 64'(2'b11));
      end
    end
  end

  // Run one instruction starting in an IDLE cycle, just after a rising edge.
  // noise: 0 clean inputs, 1 random start/flags/target outside their sampling
  // cycles, 2 start held high the whole time.
  task automatic run_instr(input int kind, input logic [2:0] f3, input logic [4:0] rd,
                           input logic eq_i, input logic ls_i, input logic lu_i,
                           input logic [63:0] tgt, input int noise);
    int len;
    out_t s32 [4];
    out_t s16 [4];
    logic [31:0] w;
    model(kind, f3, rd, eq_i, ls_i, lu_i, tgt, 32, len, s32);
    model(kind, f3, rd, eq_i, ls_i, lu_i, tgt, 16, len, s16);
    w = $urandom;
    w[14:12] = f3;
    w[11:7]  = rd;
    ins = w;
    w = $urandom;
    if (kind == KIND_BR)       w[24] = 1'b1;
    else if (kind == KIND_JAL) w[25:24] = 2'b10;
    else                       w[25:24] = 2'b00;
    code = w;
    exp_q[0].push_back('0);
    exp_q[1].push_back('0);
    for (int i = 0; i < len; i++) begin
      exp_q[0].push_back(s32[i]);
      exp_q[1].push_back(s16[i]);
    end
    {eq, ls, lu} = 3'($urandom);
    target = {$urandom, $urandom};
    start = 1'b1;
    @(posedge clk) #1;
    for (int c = 1; c <= len; c++) begin
      start = (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (c == 2 || noise == 0) {eq, ls, lu} = {eq_i, ls_i, lu_i};
      else                      {eq, ls, lu} = 3'($urandom);
      if (c == 3 || noise == 0) target = tgt;
      else                      target = {$urandom, $urandom};
      @(posedge clk) #1;
    end
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   len;
    out_t s [4];
    out_t want;

    rst = 1'b1; start = 1'b0; ins = '0; code = '0;
    eq = 1'b0; ls = 1'b0; lu = 1'b0; target = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) check("reset outputs", 64'(obs[g]), 64'd0);
    rst = 1'b0;
    checking_en = 1'b1;

    // Pin the model with hand-derived vectors.
    model(KIND_JAL, 3'd0, 5'd5, 1'b0, 1'b0, 1'b0, 64'h1000, 32, len, s);
    want = '0; want.load_pc = 1; want.sel_pc_next = 1; want.load_regfile = 1; want.done = 1;
    check("pin jal wb", 64'(s[3]), 64'(want));
    check("pin jal len", 64'(len), 64'd4);
    model(KIND_JALR, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h1001, 32, len, s);
    want = '0; want.load_pc = 1; want.sel_pc_next = 1; want.done = 1;
    check("pin jalr x0 wb", 64'(s[3]), 64'(want));
    model(KIND_BR, 3'd0, 5'd1, 1'b1, 1'b0, 1'b0, 64'h1002, 32, len, s);
    want = '0; want.done = 1; want.trap_misaligned = 1;
    check("pin beq trap32", 64'(s[3]), 64'(want));
    model(KIND_BR, 3'd0, 5'd1, 1'b1, 1'b0, 1'b0, 64'h1002, 16, len, s);
    want = '0; want.load_pc = 1; want.sel_pc_alu = 1; want.done = 1;
    check("pin beq wb16", 64'(s[3]), 64'(want));
    model(KIND_BR, 3'd4, 5'd1, 1'b0, 1'b0, 1'b0, 64'h1002, 32, len, s);
    want = '0; want.load_pc = 1; want.done = 1;
    check("pin blt not taken", 64'(s[3]), 64'(want));
    model(KIND_BR, 3'd2, 5'd1, 1'b0, 1'b0, 1'b0, 64'h1000, 32, len, s);
    want = '0; want.done = 1; want.trap_illegal = 1;
    check("pin illegal trap", 64'(s[1]), 64'(want));
    check("pin illegal len", 64'(len), 64'd2);

    // Directed scenarios.
    run_instr(KIND_JAL,  3'd0, 5'd5, 1'b0, 1'b0, 1'b0, 64'h1000, 0);
    run_instr(KIND_JALR, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h1001, 0);
    run_instr(KIND_BR,   3'd4, 5'd3, 1'b0, 1'b1, 1'b0, 64'h1000, 0);
    run_instr(KIND_BR,   3'd4, 5'd3, 1'b0, 1'b0, 1'b0, 64'h1002, 0);
    run_instr(KIND_BR,   3'd0, 5'd3, 1'b1, 1'b0, 1'b0, 64'h1002, 0);
    run_instr(KIND_BR,   3'd2, 5'd3, 1'b1, 1'b1, 1'b1, 64'h1000, 0);
    run_instr(KIND_BR,   3'd3, 5'd3, 1'b0, 1'b0, 1'b0, 64'h1000, 0);
    run_instr(KIND_JAL,  3'd0, 5'd7, 1'b0, 1'b0, 1'b0, 64'h1002, 0);
    run_instr(KIND_BR,   3'd4, 5'd3, 1'b0, 1'b1, 1'b0, 64'h2000, 2);
    run_instr(KIND_JALR, 3'd0, 5'd9, 1'b0, 1'b0, 1'b0, 64'h1003, 2);

    // Reset in EXEC_J returns to IDLE with all outputs low.
    checking_en = 1'b0;
    ins = 32'h0000_0280;
    code = 32'h0200_0000;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    @(posedge clk) #1;
    check("exec_j load_alu", 64'(load_alu[0]), 64'd1);
    check("exec_j sel_alu_b", 64'(sel_alu_b[1]), 64'd1);
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    for (int g = 0; g < 2; g++) check("outputs after mid reset", 64'(obs[g]), 64'd0);
    @(posedge clk) #1;
    for (int g = 0; g < 2; g++) check("idle after mid reset", 64'(obs[g]), 64'd0);
    checking_en = 1'b1;

    // Randomized instructions with noisy non-sampled inputs.
    for (int n = 0; n < 300; n++) begin
      int          kind;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [63:0] t;
      kind = $urandom_range(0, 2);
      f3   = 3'($urandom);
      rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      t    = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) t[1:0] = 2'b00;
      run_instr(kind, f3, rd, 1'($urandom), 1'($urandom), 1'($urandom), t, 1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue drained ialign32", 64'(exp_q[0].size()), 64'd0);
    check("queue drained ialign16", 64'(exp_q[1].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
